// File: rtl/ibex_csr_rmw_pkg.sv
// Shared types and the per-bit read-modify-write helper for the CSR RMW sequencer.
package ibex_csr_rmw_pkg;

  typedef enum logic [1:0] {
    CSR_READ  = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_SET   = 2'd2,
    CSR_CLEAR = 2'd3
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_CHECK = 2'd2,
    ST_RESP  = 2'd3
  } rmw_state_e;

  // Bit-sliced so it works for any CSR width; WARL-masked bits keep their old value.
  function automatic logic rmw_bit(input csr_op_e op, input logic old_b,
                                   input logic wdata_b, input logic mask_b);
    logic nb;
    case (op)
      CSR_WRITE: nb = wdata_b;
      CSR_SET:   nb = old_b | wdata_b;
      CSR_CLEAR: nb = old_b & ~wdata_b;
      default:   nb = old_b;
    endcase
    return (nb & mask_b) | (old_b & ~mask_b);
  endfunction

endpackage

// File: rtl/ibex_csr_rmw_mux.sv
// Combinational selection of one CSR instance's value, error flag, WARL mask and
// write-strobe position, with illegal-index detection (never indexes out of range).
module ibex_csr_rmw_mux
  import ibex_csr_rmw_pkg::*;
#(
  parameter int unsigned Width  = 32,
  parameter int unsigned NumCsr = 8,
  parameter int unsigned AddrW  = 8,
  parameter logic [NumCsr*Width-1:0] WarlMask = {NumCsr*Width{1'b1}}
) (
  input  logic [AddrW-1:0]        addr_i,
  input  logic [NumCsr*Width-1:0] rd_data_i,
  input  logic [NumCsr-1:0]       rd_error_i,
  output logic [Width-1:0]        data_o,
  output logic                    error_o,
  output logic [Width-1:0]        mask_o,
  output logic [NumCsr-1:0]       onehot_o,
  output logic                    illegal_o
);

  // AND-OR selection: an illegal index simply matches no slice and yields zeros.
  always_comb begin
    data_o    = '0;
    error_o   = 1'b0;
    mask_o    = '0;
    onehot_o  = '0;
    illegal_o = ({1'b0, addr_i} >= (AddrW+1)'(NumCsr));
    for (int k = 0; k < NumCsr; k++) begin
      onehot_o[k] = (addr_i == AddrW'(k));
      data_o      = data_o  | ({Width{onehot_o[k]}} & rd_data_i[k*Width +: Width]);
      mask_o      = mask_o  | ({Width{onehot_o[k]}} & WarlMask[k*Width +: Width]);
      error_o     = error_o | (onehot_o[k] & rd_error_i[k]);
    end
  end

endmodule

// File: rtl/ibex_csr_rmw.sv
// CSR read-modify-write sequencer: IDLE -> EXEC -> (CHECK) -> RESP.
// Optional readback check of written values enabled by IBEX_CSR_RMW_READBACK_EN.
module ibex_csr_rmw
  import ibex_csr_rmw_pkg::*;
#(
  parameter int unsigned Width  = 32,
  parameter int unsigned NumCsr = 8,
  parameter int unsigned AddrW  = 8,
  parameter logic [NumCsr*Width-1:0] WarlMask = {NumCsr*Width{1'b1}}
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [1:0]              req_op_i,
  input  logic [AddrW-1:0]        req_addr_i,
  input  logic [Width-1:0]        req_wdata_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [Width-1:0]        resp_rdata_o,
  output logic                    resp_error_o,
  output logic [NumCsr-1:0]       csr_wr_en_o,
  output logic [Width-1:0]        csr_wr_data_o,
  input  logic [NumCsr*Width-1:0] csr_rd_data_i,
  input  logic [NumCsr-1:0]       csr_rd_error_i,
  output logic                    alarm_o
);

  rmw_state_e        state_q;
  logic [AddrW-1:0]  addr_q;
  logic [NumCsr-1:0] wr_en_q;
  logic [Width-1:0]  wr_data_q;
  logic [Width-1:0]  rdata_q;
  logic              error_q;
  logic              valid_q;
  logic              alarm_q;

  logic [AddrW-1:0]  sel_addr_s;
  logic [Width-1:0]  sel_data_s;
  logic              sel_err_s;
  logic [Width-1:0]  sel_mask_s;
  logic [NumCsr-1:0] sel_onehot_s;
  logic              illegal_s;
  logic [Width-1:0]  new_val_s;
  logic              do_write_s;
  logic              req_fire_s;
  logic              alarm_set_s;
  csr_op_e           op_s;

  // The new value is computed at accept so the strobe can be a register during EXEC.
  assign sel_addr_s = (state_q == ST_IDLE) ? req_addr_i : addr_q;
  assign op_s       = csr_op_e'(req_op_i);
  assign req_fire_s = req_valid_i & req_ready_o;

  ibex_csr_rmw_mux #(
    .Width   (Width),
    .NumCsr  (NumCsr),
    .AddrW   (AddrW),
    .WarlMask(WarlMask)
  ) u_mux (
    .addr_i    (sel_addr_s),
    .rd_data_i (csr_rd_data_i),
    .rd_error_i(csr_rd_error_i),
    .data_o    (sel_data_s),
    .error_o   (sel_err_s),
    .mask_o    (sel_mask_s),
    .onehot_o  (sel_onehot_s),
    .illegal_o (illegal_s)
  );

  // New CSR value and whether this access writes at all.
  always_comb begin
    new_val_s = '0;
    for (int i = 0; i < Width; i++) begin
      new_val_s[i] = rmw_bit(op_s, sel_data_s[i], req_wdata_i[i], sel_mask_s[i]);
    end
    do_write_s = ~illegal_s &
                 ((op_s == CSR_WRITE) |
                  (((op_s == CSR_SET) | (op_s == CSR_CLEAR)) & (|req_wdata_i)));
  end

`ifdef IBEX_CSR_RMW_READBACK_EN
  logic wr_q;
  logic mismatch_s;

  // Readback mismatch is only meaningful in CHECK, one cycle after the strobe landed.
  always_comb begin
    mismatch_s  = (state_q == ST_CHECK) & (sel_data_s != wr_data_q);
    alarm_set_s = (|csr_rd_error_i) | mismatch_s;
  end
`else
  // Sticky alarm source: any instance integrity error.
  always_comb begin
    alarm_set_s = |csr_rd_error_i;
  end
`endif

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      valid_q   <= 1'b0;
      alarm_q   <= 1'b0;
`ifdef IBEX_CSR_RMW_READBACK_EN
      wr_q      <= 1'b0;
`endif
    end else begin
      alarm_q <= alarm_q | alarm_set_s;
      case (state_q)
        ST_IDLE: begin
          if (req_fire_s) begin
            addr_q <= req_addr_i;
            if (do_write_s) begin
              wr_en_q   <= sel_onehot_s;
              wr_data_q <= new_val_s;
            end
`ifdef IBEX_CSR_RMW_READBACK_EN
            wr_q    <= do_write_s;
`endif
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          wr_en_q <= '0;
          rdata_q <= illegal_s ? '0 : sel_data_s;
          error_q <= illegal_s | sel_err_s;
`ifdef IBEX_CSR_RMW_READBACK_EN
          valid_q <= ~wr_q;
          state_q <= wr_q ? ST_CHECK : ST_RESP;
`else
          valid_q <= 1'b1;
          state_q <= ST_RESP;
`endif
        end
`ifdef IBEX_CSR_RMW_READBACK_EN
        ST_CHECK: begin
          error_q <= error_q | mismatch_s;
          valid_q <= 1'b1;
          state_q <= ST_RESP;
        end
`endif
        ST_RESP: begin
          if (resp_ready_i) begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          wr_en_q <= '0;
          valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o   = rst_ni & (state_q == ST_IDLE);
  assign resp_valid_o  = valid_q;
  assign resp_rdata_o  = rdata_q;
  assign resp_error_o  = error_q;
  assign csr_wr_en_o   = wr_en_q;
  assign csr_wr_data_o = wr_data_q;
  assign alarm_o       = alarm_q;

endmodule
